delay_tab_sweep_ctrl: RTL and testbench

Delay-tab sweep scheduler for the test core. It steps one transceiver's receive delay tab across a programmed range and runs a fixed number of loop-interface pattern loops at each tab. It records a pass/fail bitmap and then programs the centre of the longest contiguous passing window back into the transceiver. It sits between the control/status banks and the loop interface and replaces manual tab writes from the PC during eye-window calibration.

---
 rtl/delay_tab_sweep_ctrl_if.sv | 37 +++
 rtl/delay_tab_sweep_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_delay_tab_sweep_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/delay_tab_sweep_ctrl_if.sv
// Control, status and loop-interface signals of the delay-tab sweep scheduler.
// The slave modport is the scheduler; the master modport is the bank/loop side driving it.
interface delay_tab_sweep_ctrl_if #(
    parameter int unsigned TAB_WIDTH = 5
);
    logic                         i_start;
    logic                         i_abort;
    logic [TAB_WIDTH-1:0]         i_tab_min;
    logic [TAB_WIDTH-1:0]         i_tab_max;
    logic                         o_wr_delay_tabs;
    logic [TAB_WIDTH-1:0]         o_delay_tabs;
    logic                         o_loop_start;
    logic                         i_loop_done;
    logic                         i_loop_fail;
    logic                         i_loop_timeout;
    logic                         o_busy;
    logic                         o_done;
    logic                         o_range_err;
    logic                         o_no_window;
    logic [(1 << TAB_WIDTH)-1:0]  o_pass_map;
    logic [TAB_WIDTH-1:0]         o_best_tab;
    logic [TAB_WIDTH:0]           o_win_len;

    modport master (
        output i_start, i_abort, i_tab_min, i_tab_max,
        output i_loop_done, i_loop_fail, i_loop_timeout,
        input  o_wr_delay_tabs, o_delay_tabs, o_loop_start, o_busy, o_done,
        input  o_range_err, o_no_window, o_pass_map, o_best_tab, o_win_len
    );

    modport slave (
        input  i_start, i_abort, i_tab_min, i_tab_max,
        input  i_loop_done, i_loop_fail, i_loop_timeout,
        output o_wr_delay_tabs, o_delay_tabs, o_loop_start, o_busy, o_done,
        output o_range_err, o_no_window, o_pass_map, o_best_tab, o_win_len
    );
endinterface

// File: rtl/delay_tab_sweep_ctrl.sv
// Delay-tab sweep scheduler: steps the receive delay tab over [min, max], runs pattern loops
// per tab, builds a pass map and finally writes the centre of the longest passing window.
module delay_tab_sweep_ctrl #(
    parameter int unsigned TAB_WIDTH     = 5,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned LOOPS_PER_TAB = 4
) (
    input logic                   i_clk,
    input logic                   i_arst,
    delay_tab_sweep_ctrl_if.slave bus
);
    localparam int unsigned MAP_W  = 1 << TAB_WIDTH;
    localparam int unsigned LEN_W  = TAB_WIDTH + 1;
    localparam int unsigned SET_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned LOOP_W = $clog2(LOOPS_PER_TAB + 1);

    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [LOOP_W-1:0] LOOP_LAST   = LOOP_W'(LOOPS_PER_TAB);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SET_TAB   = 3'd1;
    localparam logic [2:0] SETTLE    = 3'd2;
    localparam logic [2:0] RUN       = 3'd3;
    localparam logic [2:0] WAIT      = 3'd4;
    localparam logic [2:0] EVAL      = 3'd5;
    localparam logic [2:0] FINAL_SET = 3'd6;
    localparam logic [2:0] DONE      = 3'd7;

    logic [2:0]           state_q, state_d;
    logic [TAB_WIDTH-1:0] tab_q, tab_d;
    logic [TAB_WIDTH-1:0] tab_min_q, tab_min_d;
    logic [TAB_WIDTH-1:0] tab_max_q, tab_max_d;
    logic [SET_W-1:0]     settle_cnt_q, settle_cnt_d;
    logic [LOOP_W-1:0]    loop_cnt_q, loop_cnt_d;
    logic                 tab_fail_q, tab_fail_d;
    logic [LEN_W-1:0]     cur_len_q, cur_len_d;
    logic [TAB_WIDTH-1:0] cur_start_q, cur_start_d;
    logic [LEN_W-1:0]     best_len_q, best_len_d;
    logic [TAB_WIDTH-1:0] best_start_q, best_start_d;

    logic                 wr_q, wr_d;
    logic [TAB_WIDTH-1:0] delay_tabs_q, delay_tabs_d;
    logic                 loop_start_q, loop_start_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 range_err_q, range_err_d;
    logic                 no_window_q, no_window_d;
    logic [MAP_W-1:0]     pass_map_q, pass_map_d;
    logic [TAB_WIDTH-1:0] best_tab_q, best_tab_d;
    logic [LEN_W-1:0]     win_len_q, win_len_d;

    logic [LOOP_W-1:0]    loop_next;
    logic                 fail_next;
    logic [LEN_W-1:0]     best_half;

    always_comb begin
        state_d      = state_q;
        tab_d        = tab_q;
        tab_min_d    = tab_min_q;
        tab_max_d    = tab_max_q;
        settle_cnt_d = settle_cnt_q;
        loop_cnt_d   = loop_cnt_q;
        tab_fail_d   = tab_fail_q;
        cur_len_d    = cur_len_q;
        cur_start_d  = cur_start_q;
        best_len_d   = best_len_q;
        best_start_d = best_start_q;
        wr_d         = 1'b0;
        delay_tabs_d = delay_tabs_q;
        loop_start_d = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        range_err_d  = range_err_q;
        no_window_d  = no_window_q;
        pass_map_d   = pass_map_q;
        best_tab_d   = best_tab_q;
        win_len_d    = win_len_q;
        loop_next    = loop_cnt_q + LOOP_W'(1);
        fail_next    = tab_fail_q | bus.i_loop_fail;
        best_half    = (best_len_q - LEN_W'(1)) >> 1;

        if (state_q != IDLE && bus.i_abort) begin
            // Abort keeps the partial map and result registers; the tab is left where it is.
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_start) begin
                        if (bus.i_tab_min <= bus.i_tab_max) begin
                            tab_min_d    = bus.i_tab_min;
                            tab_max_d    = bus.i_tab_max;
                            tab_d        = bus.i_tab_min;
                            pass_map_d   = '0;
                            cur_len_d    = '0;
                            cur_start_d  = '0;
                            best_len_d   = '0;
                            best_start_d = '0;
                            range_err_d  = 1'b0;
                            no_window_d  = 1'b0;
                            busy_d       = 1'b1;
                            state_d      = SET_TAB;
                        end else begin
                            range_err_d = 1'b1;
                        end
                    end
                end
                SET_TAB: begin
                    wr_d         = 1'b1;
                    delay_tabs_d = tab_q;
                    loop_cnt_d   = '0;
                    tab_fail_d   = 1'b0;
                    settle_cnt_d = '0;
                    state_d      = SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_d = RUN;
                    end else begin
                        settle_cnt_d = settle_cnt_q + SET_W'(1);
                    end
                end
                RUN: begin
                    loop_start_d = 1'b1;
                    state_d      = WAIT;
                end
                WAIT: begin
                    // A timeout outranks a simultaneous done and skips the remaining loops.
                    if (bus.i_loop_timeout) begin
                        tab_fail_d = 1'b1;
                        state_d    = EVAL;
                    end else if (bus.i_loop_done) begin
                        tab_fail_d = fail_next;
                        loop_cnt_d = loop_next;
                        state_d    = (loop_next == LOOP_LAST || fail_next) ? EVAL : RUN;
                    end
                end
                EVAL: begin
                    pass_map_d[tab_q] = ~tab_fail_q;
                    if (!tab_fail_q) begin
                        cur_len_d = cur_len_q + LEN_W'(1);
                        if (cur_len_q == '0) begin
                            cur_start_d = tab_q;
                        end
                    end else begin
                        cur_len_d = '0;
                    end
                    // Strictly greater, so the lowest of equal-length windows is kept.
                    if (cur_len_d > best_len_q) begin
                        best_len_d   = cur_len_d;
                        best_start_d = cur_start_d;
                    end
                    if (tab_q == tab_max_q) begin
                        state_d = FINAL_SET;
                    end else begin
                        tab_d   = tab_q + TAB_WIDTH'(1);
                        state_d = SET_TAB;
                    end
                end
                FINAL_SET: begin
                    if (best_len_q == '0) begin
                        best_tab_d  = tab_min_q;
                        no_window_d = 1'b1;
                    end else begin
                        best_tab_d = best_start_q + TAB_WIDTH'(best_half);
                    end
                    win_len_d    = best_len_q;
                    wr_d         = 1'b1;
                    delay_tabs_d = best_tab_d;
                    state_d      = DONE;
                end
                DONE: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q      <= IDLE;
            tab_q        <= '0;
            tab_min_q    <= '0;
            tab_max_q    <= '0;
            settle_cnt_q <= '0;
            loop_cnt_q   <= '0;
            tab_fail_q   <= 1'b0;
            cur_len_q    <= '0;
            cur_start_q  <= '0;
            best_len_q   <= '0;
            best_start_q <= '0;
            wr_q         <= 1'b0;
            delay_tabs_q <= '0;
            loop_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            range_err_q  <= 1'b0;
            no_window_q  <= 1'b0;
            pass_map_q   <= '0;
            best_tab_q   <= '0;
            win_len_q    <= '0;
        end else begin
            state_q      <= state_d;
            tab_q        <= tab_d;
            tab_min_q    <= tab_min_d;
            tab_max_q    <= tab_max_d;
            settle_cnt_q <= settle_cnt_d;
            loop_cnt_q   <= loop_cnt_d;
            tab_fail_q   <= tab_fail_d;
            cur_len_q    <= cur_len_d;
            cur_start_q  <= cur_start_d;
            best_len_q   <= best_len_d;
            best_start_q <= best_start_d;
            wr_q         <= wr_d;
            delay_tabs_q <= delay_tabs_d;
            loop_start_q <= loop_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            range_err_q  <= range_err_d;
            no_window_q  <= no_window_d;
            pass_map_q   <= pass_map_d;
            best_tab_q   <= best_tab_d;
            win_len_q    <= win_len_d;
        end
    end

    assign bus.o_wr_delay_tabs = wr_q;
    assign bus.o_delay_tabs    = delay_tabs_q;
    assign bus.o_loop_start    = loop_start_q;
    assign bus.o_busy          = busy_q;
    assign bus.o_done          = done_q;
    assign bus.o_range_err     = range_err_q;
    assign bus.o_no_window     = no_window_q;
    assign bus.o_pass_map      = pass_map_q;
    assign bus.o_best_tab      = best_tab_q;
    assign bus.o_win_len       = win_len_q;
endmodule

// File: tb/tb_delay_tab_sweep_ctrl.sv
// Directed bench for delay_tab_sweep_ctrl: a loop responder plays per-tab outcomes, and a
// window model queues the expected sweep results that are compared at each o_done.
module tb_delay_tab_sweep_ctrl;
    localparam int unsigned TW     = 5;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned LOOPS  = 4;
    localparam int          LAT    = 3;

    typedef struct {
        logic [31:0] map;
        int          win;
        int          best;
        int          nowin;
        int          writes;
    } exp_t;

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    delay_tab_sweep_ctrl_if #(.TAB_WIDTH(TW)) bus ();

    delay_tab_sweep_ctrl #(
        .TAB_WIDTH    (TW),
        .SETTLE_CYCLES(SETTLE),
        .LOOPS_PER_TAB(LOOPS)
    ) dut (
        .i_clk (clk),
        .i_arst(arst),
        .bus   (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    int   mode   [32];  // 0 pass, 1 fail flag, 2 timeout on loop 2, 3 done+timeout on loop 1
    int   starts [32];
    int   wr_cnt;
    int   done_cnt;
    exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic set_modes(input int m);
        for (int t = 0; t < 32; t++) mode[t] = m;
    endtask

    // Longest passing run found by measuring forward from every run start.
    function automatic exp_t model(input int lo, input int hi);
        exp_t e;
        int   best_len;
        int   best_start;
        e.map      = '0;
        best_len   = 0;
        best_start = 0;
        for (int t = lo; t <= hi; t++) if (mode[t] == 0) e.map[t] = 1'b1;
        for (int s = lo; s <= hi; s++) begin
            if (e.map[s] && (s == lo || !e.map[s-1])) begin
                int n = 0;
                while (s + n <= hi && e.map[s+n]) n++;
                if (n > best_len) begin
                    best_len   = n;
                    best_start = s;
                end
            end
        end
        e.win    = best_len;
        e.best   = (best_len > 0) ? best_start + (best_len - 1) / 2 : lo;
        e.nowin  = (best_len == 0) ? 1 : 0;
        e.writes = hi - lo + 2;
        return e;
    endfunction

    task automatic run_sweep(input int lo, input int hi, input int abort_tab);
        int   pend, loop_idx, cur_tab, cyc, post, done_drv_cyc, last_wr_cyc;
        bit   first, first_ls, gap_chk, aborted, abort_chk, seen_done, finished;
        exp_t e;
        wr_cnt   = 0;
        done_cnt = 0;
        for (int t = 0; t < 32; t++) starts[t] = 0;
        pend = 0; loop_idx = 0; cur_tab = lo; cyc = 0; post = 0;
        done_drv_cyc = -10; last_wr_cyc = 0;
        first = 1; first_ls = 1; gap_chk = 1; aborted = 0; abort_chk = 0;
        seen_done = 0; finished = 0;
        @(negedge clk);
        bus.i_tab_min = TW'(lo);
        bus.i_tab_max = TW'(hi);
        bus.i_start   = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        check("busy_rise", bus.o_busy, 1);
        check("wr_not_yet", bus.o_wr_delay_tabs, 0);
        check("range_err_clear", bus.o_range_err, 0);
        while (!finished) begin
            @(negedge clk);
            cyc++;
            bus.i_loop_done    = 1'b0;
            bus.i_loop_fail    = 1'b0;
            bus.i_loop_timeout = 1'b0;
            bus.i_abort        = 1'b0;
            if (first) begin
                check("first_wr", bus.o_wr_delay_tabs, 1);
                check("first_tab", bus.o_delay_tabs, lo);
                first = 0;
            end
            if (abort_chk) begin
                check("abort_busy_drop", bus.o_busy, 0);
                abort_chk = 0;
            end
            if (bus.o_wr_delay_tabs) begin
                wr_cnt++;
                cur_tab     = int'(bus.o_delay_tabs);
                loop_idx    = 0;
                last_wr_cyc = cyc;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    done_drv_cyc = cyc;
                    case (mode[cur_tab])
                        1: begin bus.i_loop_done = 1'b1; bus.i_loop_fail = 1'b1; end
                        2: if (loop_idx == 2) bus.i_loop_timeout = 1'b1;
                           else bus.i_loop_done = 1'b1;
                        3: begin
                            bus.i_loop_done = 1'b1;
                            if (loop_idx == 1) bus.i_loop_timeout = 1'b1;
                        end
                        default: bus.i_loop_done = 1'b1;
                    endcase
                end
            end
            if (bus.o_loop_start) begin
                if (first_ls) begin
                    check("first_loop_start_cyc", cyc, 2 + SETTLE);
                    first_ls = 0;
                end else if (gap_chk && loop_idx > 0) begin
                    check("loop_start_after_done", cyc, done_drv_cyc + 2);
                    gap_chk = 0;
                end
                loop_idx++;
                starts[cur_tab]++;
                if (cur_tab == abort_tab && !aborted) begin
                    bus.i_abort = 1'b1;
                    aborted     = 1;
                    abort_chk   = 1;
                end else begin
                    pend = LAT;
                end
            end
            if (bus.o_done) begin
                done_cnt++;
                if (!seen_done && sb.size() > 0) begin
                    e = sb.pop_front();
                    check("pass_map", bus.o_pass_map, e.map);
                    check("win_len", bus.o_win_len, e.win);
                    check("best_tab", bus.o_best_tab, e.best);
                    check("no_window", bus.o_no_window, e.nowin);
                    check("tab_writes", wr_cnt, e.writes);
                    check("final_tab_held", bus.o_delay_tabs, e.best);
                    check("done_after_final_wr", cyc, last_wr_cyc + 1);
                    check("busy_low_at_done", bus.o_busy, 0);
                end
                seen_done = 1;
            end
            if (seen_done || aborted) post++;
            if (post >= (aborted ? 40 : 5)) finished = 1;
            if (cyc > 6000) begin
                check("sweep_budget", seen_done, 1);
                finished = 1;
            end
        end
    endtask

    initial begin
        int busy_seen, wr_seen;
        arst               = 1'b1;
        bus.i_start        = 1'b0;
        bus.i_abort        = 1'b0;
        bus.i_tab_min      = '0;
        bus.i_tab_max      = '0;
        bus.i_loop_done    = 1'b0;
        bus.i_loop_fail    = 1'b0;
        bus.i_loop_timeout = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.o_busy, 0);
        check("rst_delay_tabs", bus.o_delay_tabs, 0);
        check("rst_pass_map", bus.o_pass_map, 0);
        check("rst_best_tab", bus.o_best_tab, 0);
        check("rst_win_len", bus.o_win_len, 0);
        arst = 1'b0;

        // min > max: only the range error flag moves.
        @(negedge clk);
        bus.i_tab_min = 5'd10;
        bus.i_tab_max = 5'd3;
        bus.i_start   = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        busy_seen   = 0;
        wr_seen     = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.o_busy) busy_seen++;
            if (bus.o_wr_delay_tabs) wr_seen++;
            @(negedge clk);
        end
        check("range_err_set", bus.o_range_err, 1);
        check("range_busy_seen", busy_seen, 0);
        check("range_wr_seen", wr_seen, 0);

        // Full range, everything passes.
        set_modes(0);
        sb.push_back(model(0, 31));
        run_sweep(0, 31, -1);
        check("full_done_once", done_cnt, 1);
        check("full_win_len", bus.o_win_len, 32);
        check("full_best_tab", bus.o_best_tab, 15);
        check("full_loops_tab0", starts[0], LOOPS);

        // 4..12 with failures on 4, 5, 9, 12.
        set_modes(0);
        mode[4] = 1; mode[5] = 1; mode[9] = 1; mode[12] = 1;
        sb.push_back(model(4, 12));
        run_sweep(4, 12, -1);
        check("w1_pass_map", bus.o_pass_map, 32'h0000_0DC0);
        check("w1_best_tab", bus.o_best_tab, 7);
        check("w1_fail_loops", starts[4], 1);

        // Two equal windows 6-7 and 10-11: the lower one wins.
        set_modes(0);
        mode[4] = 1; mode[5] = 1; mode[8] = 1; mode[9] = 1; mode[12] = 1;
        sb.push_back(model(4, 12));
        run_sweep(4, 12, -1);
        check("tie_best_tab", bus.o_best_tab, 6);
        check("tie_win_len", bus.o_win_len, 2);

        // Timeout on loop 2 of tab 3; done+timeout together on tab 5.
        set_modes(0);
        mode[3] = 2;
        mode[5] = 3;
        sb.push_back(model(0, 7));
        run_sweep(0, 7, -1);
        check("tmo_loop_starts", starts[3], 2);
        check("tmo_next_tab_loops", starts[4], LOOPS);
        check("both_loop_starts", starts[5], 1);
        check("tmo_map_bits", bus.o_pass_map[5:3], 3'b010);

        // Every loop fails.
        set_modes(1);
        sb.push_back(model(2, 6));
        run_sweep(2, 6, -1);
        check("nowin_flag", bus.o_no_window, 1);
        check("nowin_best_tab", bus.o_best_tab, 2);
        check("nowin_win_len", bus.o_win_len, 0);

        // Abort while waiting on the first loop of tab 3.
        set_modes(0);
        run_sweep(0, 7, 3);
        check("abort_no_done", done_cnt, 0);
        check("abort_busy", bus.o_busy, 0);
        check("abort_partial_map", bus.o_pass_map, 32'h0000_0007);
        check("abort_best_kept", bus.o_best_tab, 2);
        check("abort_win_kept", bus.o_win_len, 0);
        check("abort_sb_empty", sb.size(), 0);

        // Reset while settling after the first tab write.
        @(negedge clk);
        bus.i_tab_min = 5'd9;
        bus.i_tab_max = 5'd12;
        bus.i_start   = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        @(negedge clk);
        check("pre_rst_wr", bus.o_wr_delay_tabs, 1);
        arst = 1'b1;
        #1;
        check("mid_rst_busy", bus.o_busy, 0);
        check("mid_rst_wr", bus.o_wr_delay_tabs, 0);
        check("mid_rst_delay_tabs", bus.o_delay_tabs, 0);
        check("mid_rst_best_tab", bus.o_best_tab, 0);
        check("mid_rst_others", {bus.o_loop_start, bus.o_done, bus.o_range_err,
                                 bus.o_no_window, bus.o_pass_map, bus.o_win_len}, 0);
        @(negedge clk);
        arst = 1'b0;
        repeat (SETTLE + 4) @(negedge clk);
        check("post_rst_idle", {bus.o_busy, bus.o_loop_start}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
